apb_regfile_completer: RTL and testbench

APB completer (slave) that terminates transfers issued by `apb_master`: an indexed register file with a fixed wait-state count, a read-only ID word, and error signalling on illegal accesses. Sits on one PSELx line of the APB fabric, next to the existing slaves. It generates PREADY and PSLVERR itself, so the master's wait and error paths can be exercised.

---
 rtl/apb_regfile_completer.sv | 126 ++++++++++++
 tb/tb_apb_regfile_completer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_completer.sv
// APB completer: indexed register file with fixed wait states, read-only ID word at index 0, and PSLVERR on illegal accesses.
// Optional byte-strobe writes are enabled by defining APB_REGFILE_PSTRB_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no transfer; a setup phase latches index/direction/error
// S_ACCESS | wait counter running; PREADY rises when it reaches zero
// S_DONE   | one-cycle turnaround; a setup here is accepted like S_IDLE
module apb_regfile_completer #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [31:0]             PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_REGFILE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx_q;
  logic                  wr_q;
  logic                  err_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  setup;
  logic                  accept;
  logic                  ready;
  logic                  commit;
  logic                  addr_err;
  logic [IDX_W-1:0]      addr_idx;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign setup    = PSELx && !PENABLE;
  assign accept   = setup && (state == S_IDLE || state == S_DONE);
  assign addr_idx = PADDR[IDX_W+1:2];
  // Unaligned, out of the index range, or a write to the ID word.
  assign addr_err = (PADDR[1:0] != 2'b00)
                 || ((PADDR >> (IDX_W + 2)) != 32'd0)
                 || (PWRITE && (addr_idx == '0));

  assign ready  = (state == S_ACCESS) && PSELx && PENABLE && (cnt_q == 4'd0);
  assign commit = ready && wr_q && !err_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (setup) state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (!PSELx)     state_nxt = S_IDLE;
        else if (ready) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = setup ? S_ACCESS : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    PREADY  = ready;
    PSLVERR = ready && err_q;
    PRDATA  = '0;
    if (ready && !err_q && !wr_q) PRDATA = rd_word;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      idx_q <= '0;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      idx_q <= addr_idx;
      wr_q  <= PWRITE;
      err_q <= addr_err;
      cnt_q <= 4'(WAIT_STATES);
    end else if (state == S_ACCESS && PSELx && PENABLE && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

`ifdef APB_REGFILE_PSTRB_EN
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) wr_mask[8*b +: 8] = {8{PSTRB[b]}};
  end
`else
  assign wr_mask = '1;
`endif

  assign rd_word = (idx_q == '0) ? ID_VALUE : regs[idx_q];
  assign wr_word = (regs[idx_q] & ~wr_mask) | (PWDATA & wr_mask);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[idx_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Directed bench for apb_regfile_completer (default parameters, WAIT_STATES=1).
// Inputs change 1ns after the rising edge; outputs are sampled 5ns after it.
module tb_apb_regfile_completer;

  logic        PCLK;
  logic        PRESET;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  apb_regfile_completer dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSELx   (PSELx),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
`ifdef APB_REGFILE_PSTRB_EN
    .PSTRB   (PSTRB),
`endif
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Full transfer; acc_cycles = access cycle index where PREADY was seen, 0 on timeout.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic slverr, output int acc_cycles);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    acc_cycles = 0; rdata = '0; slverr = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      #4;
      if (PREADY) begin
        rdata = PRDATA; slverr = PSLVERR; acc_cycles = n;
        break;
      end
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int cyc;
    PRESET = 1'b1; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    repeat (3) @(posedge PCLK);
    #5;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b required 0", PREADY); end
    checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b required 0", PSLVERR); end
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h required 0", PRDATA); end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    apb_xfer(1'b0, 32'd0, 32'd0, 4'hF, rd, err, cyc);
    checks++; if (rd !== ID) begin errors++; $display("FAIL id_read: got %h required %h", rd, ID); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL id_pslverr: got %b required 0", err); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL id_latency: got %0d required 2", cyc); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 32'd24, 32'd69, 4'hF, rd, err, cyc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr24_pslverr: got %b required 0", err); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL wr24_latency: got %0d required 2", cyc); end
    apb_xfer(1'b0, 32'd24, 32'd0, 4'hF, rd, err, cyc);
    checks++; if (rd !== 32'd69) begin errors++; $display("FAIL rd24: got %h required %h", rd, 32'd69); end
    for (int i = 1; i < 8; i++) begin
      if (i == 6) continue;
      apb_xfer(1'b0, 32'(i * 4), 32'd0, 4'hF, rd, err, cyc);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_idx%0d: got %h required 0", i, rd); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 32'd0, 32'h1234_5678, 4'hF, rd, err, cyc);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wr0_pslverr: got %b required 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr0_prdata: got %h required 0", rd); end
    apb_xfer(1'b1, 32'd1, 32'h1234_5678, 4'hF, rd, err, cyc);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wr1_pslverr: got %b required 1", err); end
    apb_xfer(1'b0, 32'd32, 32'd0, 4'hF, rd, err, cyc);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rd32_pslverr: got %b required 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd32_prdata: got %h required 0", rd); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL rd32_latency: got %0d required 2", cyc); end
    apb_xfer(1'b0, 32'd0, 32'd0, 4'hF, rd, err, cyc);
    checks++; if (rd !== ID) begin errors++; $display("FAIL id_after_err: got %h required %h", rd, ID); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL id_after_err_pslverr: got %b required 0", err); end
  endtask

  task automatic test_back_to_back();
    int c1 = 0; int c2 = 0; logic [31:0] rd = '0;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd8; PWDATA = 32'd30; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      #4;
      if (PREADY) begin c1 = n; break; end
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    PENABLE = 1'b0; PWRITE = 1'b0;
    #4;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL b2b_done_pready: got %b required 0", PREADY); end
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      #4;
      if (PREADY) begin c2 = n; rd = PRDATA; break; end
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    checks++; if (c1 !== 2) begin errors++; $display("FAIL b2b_wr_latency: got %0d required 2", c1); end
    checks++; if (c2 !== 2) begin errors++; $display("FAIL b2b_rd_latency: got %0d required 2", c2); end
    checks++; if (rd !== 32'd30) begin errors++; $display("FAIL b2b_rd_data: got %h required %h", rd, 32'd30); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc; logic seen = 1'b0;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd16; PWDATA = 32'd9; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #4;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL abort_wait_pready: got %b required 0", PREADY); end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #4;
      if (PREADY) seen = 1'b1;
      @(posedge PCLK); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_pready_pulse: got %b required 0", seen); end
    apb_xfer(1'b0, 32'd16, 32'd0, 4'hF, rd, err, cyc);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_rd16: got %h required 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1'b1, 32'd4, 32'd2, 4'hF, rd, err, cyc);
    apb_xfer(1'b0, 32'd4, 32'd0, 4'hF, rd, err, cyc);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL rd4_before_reset: got %h required 2", rd); end
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd4; PWDATA = 32'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    #4;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL reset_mid_pready: got %b required 0", PREADY); end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    apb_xfer(1'b0, 32'd4, 32'd0, 4'hF, rd, err, cyc);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mid_rd4: got %h required 0", rd); end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL reset_mid_latency: got %0d required 2", cyc); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int cyc; logic [31:0] exp_val;
`ifdef APB_REGFILE_PSTRB_EN
    exp_val = 32'h00FF_00FF;
`else
    exp_val = 32'hFFFF_FFFF;
`endif
    apb_xfer(1'b1, 32'd12, 32'hFFFF_FFFF, 4'b0101, rd, err, cyc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL strb_wr_pslverr: got %b required 0", err); end
    apb_xfer(1'b0, 32'd12, 32'd0, 4'hF, rd, err, cyc);
    checks++; if (rd !== exp_val) begin errors++; $display("FAIL strb_rd12: got %h required %h", rd, exp_val); end
`ifdef APB_REGFILE_PSTRB_EN
    apb_xfer(1'b1, 32'd12, 32'hAAAA_AAAA, 4'b0000, rd, err, cyc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL strb0_pslverr: got %b required 0", err); end
    apb_xfer(1'b0, 32'd12, 32'd0, 4'hF, rd, err, cyc);
    checks++; if (rd !== exp_val) begin errors++; $display("FAIL strb0_rd12: got %h required %h", rd, exp_val); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_strobe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
